// File: rtl/oam_dma_ctrl_pkg.sv
// Shared definitions for the OAM DMA controller: state encoding and the
// two register addresses the controller cares about.
package oam_dma_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4
    } dma_state_t;

    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller. A CPU write to OAMDMA_ADDR stalls the CPU and copies
// the 256-byte page {P, 8'h00..8'hFF} into OAMDATA_ADDR, one byte per
// get/put cycle pair. Reads only happen on get cycles (parity 0), so a
// trigger landing on the wrong parity costs one extra ALIGN cycle.
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_rw,
    input  logic [7:0]  bus_rdata,
    output logic        dma_busy
);

    dma_state_t state;
    logic       parity;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_latch;

    // CPU read data is never intercepted; the bus result goes straight back.
    assign cpu_rdata = bus_rdata;

    // Sequencer: parity tracking, trigger detection, read/write stepping and
    // the registered CPU handshake outputs that follow the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            parity     <= 1'b0;
            page       <= 8'h00;
            idx        <= 8'h00;
            data_latch <= 8'h00;
            cpu_rdy    <= 1'b1;
            dma_busy   <= 1'b0;
        end else begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (!cpu_rw && cpu_addr == OAMDMA_ADDR) begin
                        page     <= cpu_wdata;
                        state    <= HALT;
                        cpu_rdy  <= 1'b0;
                        dma_busy <= 1'b1;
                    end
                end
                HALT: begin
                    // The next cycle's parity is the inverse of the current one,
                    // so a parity-1 HALT is followed directly by a get cycle.
                    if (parity) begin
                        state <= READ;
                    end else begin
                        state <= ALIGN;
                    end
                end
                ALIGN: begin
                    state <= READ;
                end
                READ: begin
                    data_latch <= bus_rdata;
                    state      <= WRITE;
                end
                WRITE: begin
                    idx <= idx + 8'd1;
                    if (idx == 8'hFF) begin
                        state    <= IDLE;
                        cpu_rdy  <= 1'b1;
                        dma_busy <= 1'b0;
                    end else begin
                        state <= READ;
                    end
                end
                default: begin
                    state    <= IDLE;
                    cpu_rdy  <= 1'b1;
                    dma_busy <= 1'b0;
                end
            endcase
        end
    end

    // Bus ownership mux: the CPU drives the bus in IDLE, the DMA otherwise.
    // HALT and ALIGN issue harmless dummy reads at the CPU's address.
    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_rw    = cpu_rw;
        case (state)
            HALT, ALIGN: begin
                bus_addr  = cpu_addr;
                bus_wdata = 8'h00;
                bus_rw    = 1'b1;
            end
            READ: begin
                bus_addr  = {page, idx};
                bus_wdata = 8'h00;
                bus_rw    = 1'b1;
            end
            WRITE: begin
                bus_addr  = OAMDATA_ADDR;
                bus_wdata = data_latch;
                bus_rw    = 1'b0;
            end
            default: begin
                bus_addr  = cpu_addr;
                bus_wdata = cpu_wdata;
                bus_rw    = cpu_rw;
            end
        endcase
    end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Testbench for oam_dma_ctrl: the bench acts as memory (byte = low address
// byte ^ 8'h5A) and keeps a queue of the bus cycles each DMA must produce.
module tb_oam_dma_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_rw;
    logic [7:0]  bus_rdata;
    logic        dma_busy;

    int checks = 0;
    int errors = 0;

    // Expected DMA-owned bus cycle; kind 0 = halt/align, 1 = read, 2 = write
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  data;
    } bus_txn_t;

    bus_txn_t exp_q[$];

    // Expected parity of the current cycle, from the reset/toggle rule
    logic par_m = 1'b0;

    oam_dma_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .cpu_rdy   (cpu_rdy),
        .cpu_rdata (cpu_rdata),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rw    (bus_rw),
        .bus_rdata (bus_rdata),
        .dma_busy  (dma_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model
    assign bus_rdata = bus_addr[7:0] ^ 8'h5A;

    // Parity model
    always @(posedge clk) par_m <= reset ? 1'b0 : ~par_m;

    task automatic set_cpu(input logic [15:0] a, input logic [7:0] d, input logic rw);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_rw    = rw;
    endtask

    // Trigger a DMA of page pg on a cycle of parity want_par, then follow it.
    // abort_at > 0 asserts reset after that many stall cycles.
    task automatic run_dma(input logic [7:0] pg, input logic want_par, input int abort_at);
        bus_txn_t t;
        bus_txn_t e;
        int       stall;
        int       exp_stall;
        bit       done;
        stall = 0;
        done  = 0;
        exp_q.delete();
        set_cpu(16'h1000, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (par_m == want_par) break;
        end
        set_cpu(16'h4014, pg, 1'b0);
        // Expected DMA-owned bus cycles, pushed as the trigger is driven
        t = '{kind: 0, addr: 16'hBEEF, rw: 1'b1, data: 8'h00};
        exp_q.push_back(t);
        if (want_par) exp_q.push_back(t);
        for (int i = 0; i < 256; i++) begin
            t = '{kind: 1, addr: {pg, i[7:0]}, rw: 1'b1, data: 8'h00};
            exp_q.push_back(t);
            t = '{kind: 2, addr: 16'h2004, rw: 1'b0, data: i[7:0] ^ 8'h5A};
            exp_q.push_back(t);
        end
        exp_stall = want_par ? 514 : 513;
        @(negedge clk);
        checks++;
        if (bus_addr !== 16'h4014 || bus_rw !== 1'b0 || bus_wdata !== pg || cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL trigger_pass: got addr=%h rw=%b wdata=%h rdy=%b, want addr=4014 rw=0 wdata=%h rdy=1",
                     bus_addr, bus_rw, bus_wdata, cpu_rdy, pg);
        end
        @(posedge clk); #1;
        // Inputs during the stall look like another trigger; they must be ignored
        set_cpu(16'hBEEF, 8'h77, 1'b0);
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (cpu_rdy === 1'b1) begin
                done = 1;
                break;
            end
            stall++;
            checks++;
            if (dma_busy !== 1'b1) begin
                errors++;
                $display("FAIL busy_in_stall: cycle %0d got dma_busy=%b want 1", stall, dma_busy);
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_cycle: stall cycle %0d addr=%h rw=%b with nothing expected", stall, bus_addr, bus_rw);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (bus_addr !== e.addr || bus_rw !== e.rw) begin
                    errors++;
                    $display("FAIL bus_cycle: stall %0d kind %0d got addr=%h rw=%b want addr=%h rw=%b",
                             stall, e.kind, bus_addr, bus_rw, e.addr, e.rw);
                end
                if (e.kind != 1) begin
                    checks++;
                    if (bus_wdata !== e.data) begin
                        errors++;
                        $display("FAIL bus_wdata: stall %0d kind %0d got %h want %h", stall, e.kind, bus_wdata, e.data);
                    end
                end else begin
                    checks++;
                    if (par_m !== 1'b0) begin
                        errors++;
                        $display("FAIL read_parity: read of %h on parity %b want 0", bus_addr, par_m);
                    end
                end
            end
            if (abort_at > 0 && stall == abort_at) begin
                @(posedge clk); #1;
                reset = 1'b1;
                set_cpu(16'h1234, 8'h00, 1'b1);
                @(posedge clk); #1;
                reset = 1'b0;
                @(negedge clk);
                checks++;
                if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0 || bus_addr !== 16'h1234 || bus_rw !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_abort: got rdy=%b busy=%b addr=%h rw=%b want rdy=1 busy=0 addr=1234 rw=1",
                             cpu_rdy, dma_busy, bus_addr, bus_rw);
                end
                exp_q.delete();
                return;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL dma_timeout: cpu_rdy still %b after 700 cycles", cpu_rdy);
        end
        checks++;
        if (stall != exp_stall) begin
            errors++;
            $display("FAIL stall_count: got %0d want %0d", stall, exp_stall);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_cycles: %0d expected bus cycles never seen", exp_q.size());
        end
        checks++;
        if (dma_busy !== 1'b0 || bus_addr !== 16'hBEEF || bus_rw !== 1'b0 || bus_wdata !== 8'h77) begin
            errors++;
            $display("FAIL after_dma: got busy=%b addr=%h rw=%b wdata=%h want busy=0 addr=beef rw=0 wdata=77",
                     dma_busy, bus_addr, bus_rw, bus_wdata);
        end
        @(posedge clk); #1;
        set_cpu(16'h1000, 8'h00, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cpu(16'h4014, 8'h09, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        set_cpu(16'h1000, 8'h00, 1'b1);
        @(negedge clk);
        checks++;
        if (cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b busy=%b want rdy=1 busy=0", cpu_rdy, dma_busy);
        end
    endtask

    task automatic test_passthrough();
        @(posedge clk); #1;
        set_cpu(16'h1234, 8'h99, 1'b1);
        @(negedge clk);
        checks++;
        if (bus_addr !== 16'h1234 || bus_rw !== 1'b1 || bus_wdata !== 8'h99 || cpu_rdy !== 1'b1 || dma_busy !== 1'b0) begin
            errors++;
            $display("FAIL passthrough: got addr=%h rw=%b wdata=%h rdy=%b busy=%b want 1234 1 99 1 0",
                     bus_addr, bus_rw, bus_wdata, cpu_rdy, dma_busy);
        end
        checks++;
        if (cpu_rdata !== 8'h6E) begin
            errors++;
            $display("FAIL cpu_rdata: got %h want 6e", cpu_rdata);
        end
    endtask

    task automatic test_no_trigger();
        @(posedge clk); #1;
        set_cpu(16'h4014, 8'h02, 1'b1);
        @(posedge clk); #1;
        set_cpu(16'h4015, 8'h02, 1'b0);
        @(negedge clk);
        checks++;
        if (dma_busy !== 1'b0 || cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL read_4014: got busy=%b rdy=%b want busy=0 rdy=1", dma_busy, cpu_rdy);
        end
        @(posedge clk); #1;
        set_cpu(16'h1000, 8'h00, 1'b1);
        @(negedge clk);
        checks++;
        if (dma_busy !== 1'b0 || cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL write_4015: got busy=%b rdy=%b want busy=0 rdy=1", dma_busy, cpu_rdy);
        end
    endtask

    task automatic test_dma_even();
        run_dma(8'h02, 1'b0, 0);
    endtask

    task automatic test_dma_odd();
        run_dma(8'h02, 1'b1, 0);
    endtask

    task automatic test_page_ff();
        run_dma(8'hFF, 1'b0, 0);
        // Index must have wrapped to 0: a fresh transfer starts at offset 0
        run_dma(8'h10, 1'b1, 0);
    endtask

    task automatic test_reset_abort();
        run_dma(8'h05, 1'b1, 100);
        run_dma(8'h03, 1'b0, 0);
    endtask

    initial begin
        set_cpu(16'h0000, 8'h00, 1'b1);
        reset = 1'b1;
        test_reset();
        test_passthrough();
        test_no_trigger();
        test_dma_even();
        test_dma_odd();
        test_page_ff();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
